// File: rtl/lane_key_conditioner_if.sv
// Press-event handshake between the key conditioner (master) and the
// input checker (slave): show-ahead head entry plus a consumer ack.
interface lane_key_conditioner_if #(
  parameter int LANES = 4
);
  logic             press_valid;
  logic [LANES-1:0] press_mask;
  logic             press_ack;

  modport master (
    output press_valid,
    output press_mask,
    input  press_ack
  );

  modport slave (
    input  press_valid,
    input  press_mask,
    output press_ack
  );
endinterface

// File: rtl/lane_key_conditioner.sv
// Conditions raw active-low lane buttons: synchronise, debounce, detect the
// press edge and queue each press as a lane mask in a small show-ahead FIFO.
module lane_key_conditioner #(
  parameter int LANES           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int DEPTH           = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LANES-1:0]        key_n,
  input  logic                    enable,
  input  logic                    flush,
  lane_key_conditioner_if.master  press,
  output logic [LANES-1:0]        key_level,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  logic [LANES-1:0] sync_q [SYNC_STAGES];
  logic [LANES-1:0] pressed;

  logic [CNT_W-1:0] cnt_q [LANES];
  logic [CNT_W-1:0] cnt_d [LANES];
  logic [LANES-1:0] level_q, level_d;
  logic [LANES-1:0] levelPrev_q;
  logic [LANES-1:0] riseMask;

  logic [LANES-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             pushReq, popReq, full, doPush;

  // Released buttons read as 1, so the chain resets to all ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '1;
    end else begin
      sync_q[0] <= key_n;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign pressed = ~sync_q[SYNC_STAGES-1];

  // Counter value plus level encode IDLE_UP / COUNT_DOWN / HELD / COUNT_UP;
  // any agreement with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < LANES; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) level_d[i] = ~level_q[i];
        else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) cnt_q[i] <= '0;
      level_q     <= '0;
      levelPrev_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) cnt_q[i] <= cnt_d[i];
      level_q     <= level_d;
      levelPrev_q <= level_q;
    end
  end

  assign riseMask = level_q & ~levelPrev_q;
  assign pushReq  = enable && (riseMask != '0);
  assign popReq   = press.press_ack && (count_q != '0);
  assign full     = (count_q == CountFull);
  assign doPush   = pushReq && (!full || popReq);

  // Flush wins over any push or pop on the same edge; overflow survives it.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (doPush) wptr_q <= wptr_q + AW'(1);
        if (popReq) rptr_q <= rptr_q + AW'(1);
        case ({doPush, popReq})
          2'b10:   count_q <= count_q + (AW + 1)'(1);
          2'b01:   count_q <= count_q - (AW + 1)'(1);
          default: count_q <= count_q;
        endcase
        if (pushReq && full && !popReq) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && doPush) mem_q[wptr_q] <= riseMask;
  end

  assign press.press_valid = (count_q != '0);
  assign press.press_mask  = press.press_valid ? mem_q[rptr_q] : '0;
  assign key_level         = level_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_lane_key_conditioner.sv
// Scenario bench for lane_key_conditioner with short debounce; expected press
// masks are queued when a press is driven and compared when they are acked.
module tb_lane_key_conditioner;

  localparam int LANES = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [LANES-1:0] key_n = '1;
  logic             enable = 1'b1;
  logic             flush = 1'b0;
  logic [LANES-1:0] key_level;
  logic             overflow;

  int errors = 0;
  int checks = 0;
  logic [LANES-1:0] sb [$];

  lane_key_conditioner_if #(.LANES(LANES)) pif ();

  lane_key_conditioner #(
    .LANES(LANES), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .enable(enable),
    .flush(flush),
    .press(pif),
    .key_level(key_level),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Full press-and-release cycle; the expected mask is queued if it should land.
  task automatic pressKey(input logic [LANES-1:0] m, input bit queued);
    key_n = key_n & ~m;
    tick(7);
    if (queued) sb.push_back(m);
    key_n = key_n | m;
    tick(7);
  endtask

  // Consumes the head entry against the scoreboard, acking for one cycle.
  task automatic popCheck(input string name);
    logic [LANES-1:0] exp;
    checks++;
    if (pif.press_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_valid: got %b expected 1", name, pif.press_valid);
    end
    if (sb.size() == 0) begin
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    checks++;
    if (pif.press_mask !== exp) begin
      errors++;
      $display("[TB] FAIL %s_mask: got %b expected %b", name, pif.press_mask, exp);
    end
    pif.press_ack = 1'b1;
    tick(1);
    pif.press_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if ({pif.press_valid, pif.press_mask, key_level, overflow} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {pif.press_valid, pif.press_mask, key_level, overflow}, 10'b0);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_clean_press();
    key_n[2] = 1'b0;
    tick(5);
    checks++;
    if (key_level !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clean_level_early: got %b expected 0000", key_level);
    end
    tick(1);
    checks++;
    if (key_level !== 4'b0100 || pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_level_edge5: got level=%b valid=%b expected level=0100 valid=0",
               key_level, pif.press_valid);
    end
    tick(1);
    sb.push_back(4'b0100);
    popCheck("clean_pop");
    checks++;
    if (pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_after_ack: got %b expected 0", pif.press_valid);
    end
    key_n[2] = 1'b1;
    tick(10);
    checks++;
    if (key_level !== 4'b0000 || pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_release: got level=%b valid=%b expected level=0000 valid=0",
               key_level, pif.press_valid);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      key_n[0] = 1'b0;
      tick(2);
      key_n[0] = 1'b1;
      tick(2);
      checks++;
      if (key_level !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL bounce_level_%0d: got %b expected 0000", i, key_level);
      end
    end
    tick(8);
    checks++;
    if (pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_no_event: got %b expected 0", pif.press_valid);
    end
  endtask

  task automatic test_simultaneous();
    pressKey(4'b1010, 1'b1);
    popCheck("simul_pop");
    checks++;
    if (pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_single_entry: got %b expected 0", pif.press_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      pressKey(4'b0001, i < 4);
      if (i == 3) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ovf_at_four: got %b expected 0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int i = 0; i < 4; i++) popCheck("ovf_pop");
    checks++;
    if (pif.press_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_drained: got valid=%b ovf=%b expected valid=0 ovf=1",
               pif.press_valid, overflow);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_reset: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    pressKey(4'b0001, 1'b1);
    pressKey(4'b0010, 1'b1);
    pressKey(4'b0100, 1'b1);
    pressKey(4'b1000, 1'b1);
    key_n[0] = 1'b0;
    tick(6);
    popCheck("full_head");
    sb.push_back(4'b0001);
    checks++;
    if (overflow !== 1'b0 || pif.press_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_pushpop: got ovf=%b valid=%b expected ovf=0 valid=1",
               overflow, pif.press_valid);
    end
    key_n[0] = 1'b1;
    tick(7);
    for (int i = 0; i < 4; i++) popCheck("full_drain");
    checks++;
    if (pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_count4: got %b expected 0", pif.press_valid);
    end
    enable = 1'b0;
    pressKey(4'b0100, 1'b0);
    enable = 1'b1;
    checks++;
    if (pif.press_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL disabled_press: got valid=%b ovf=%b expected valid=0 ovf=0",
               pif.press_valid, overflow);
    end
  endtask

  task automatic test_reset_flush();
    pressKey(4'b0001, 1'b1);
    key_n[1] = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    checks++;
    if (key_level !== 4'b0000 || pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midcount_reset: got level=%b valid=%b expected level=0000 valid=0",
               key_level, pif.press_valid);
    end
    tick(5);
    checks++;
    if (key_level !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL held_level_early: got %b expected 0000", key_level);
    end
    tick(1);
    checks++;
    if (key_level !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL held_level: got %b expected 0010", key_level);
    end
    tick(1);
    sb.push_back(4'b0010);
    popCheck("held_pop");
    key_n[1] = 1'b1;
    tick(7);
    pressKey(4'b0001, 1'b1);
    pressKey(4'b0100, 1'b1);
    pressKey(4'b1000, 1'b1);
    checks++;
    if (pif.press_valid !== 1'b1 || pif.press_mask !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL preflush: got valid=%b mask=%b expected valid=1 mask=0001",
               pif.press_valid, pif.press_mask);
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    sb.delete();
    checks++;
    if (pif.press_valid !== 1'b0 || pif.press_mask !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL flush_empty: got valid=%b mask=%b expected valid=0 mask=0000",
               pif.press_valid, pif.press_mask);
    end
    pressKey(4'b0010, 1'b1);
    popCheck("postflush_pop");
    checks++;
    if (pif.press_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL postflush_empty: got %b expected 0", pif.press_valid);
    end
  endtask

  initial begin
    pif.press_ack = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_key_conditioner.md
Name: lane_key_conditioner

Overview:
- Sits between the raw active-low lane push-buttons (KEY[3:0]) and the input checker.
- Per lane: synchronises each button, debounces it and detects the press edge.
- Presses are queued as lane masks in a small FIFO with a valid/ack handshake, so each physical press is consumed exactly once, even when it occurs outside the check window.

Parameters:
LANES, 4, number of lane buttons
SYNC_STAGES, 2, synchroniser flops per lane (min 2)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to change debounced state (10 ms at 50 MHz)
CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
DEPTH, 4, event FIFO entries (power of two)

Ports:
clock  input  1  system clock (CLOCK_50 domain)
reset  input  1  synchronous, active-high reset
key_n  input  LANES  raw buttons, active-low, asynchronous
enable  input  1  1 = press events are enqueued; 0 = detected presses are discarded
flush  input  1  one-cycle pulse; empties the FIFO
press_ack  input  1  consumer pops head entry; ignored when press_valid=0
press_valid  output  1  FIFO non-empty
press_mask  output  LANES  head entry: lanes newly pressed in the same cycle (show-ahead)
key_level  output  LANES  debounced levels, 1 = held
overflow  output  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset (synchronous, active-high; overrides all other inputs that cycle):
  - Sync flops = 1 (released); debounced state = 0; counters = 0; FIFO empty.
  - press_valid = 0, press_mask = 0, key_level = 0, overflow = 0.
- Sync: key_n passes through SYNC_STAGES flops and is inverted to an active-high level s[i].
- Debounce, per lane:
  - If s[i] == key_level[i], the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, key_level[i] toggles and the counter clears.
  - Any bounce back to agreement restarts the count from 0.
- Edge detect:
  - rise[i] = key_level[i] toggling 0->1 on that edge.
  - Releases generate no event.
  - All lanes rising on the same edge form one mask entry.
- Enqueue:
  - On the edge after a non-zero rise mask with enable=1, the mask is pushed.
  - With enable=0 the mask is dropped silently; overflow is not set.
- Latency: taking the first edge that samples key_n low as edge 0:
  - key_level rises after edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - press_valid rises after edge SYNC_STAGES+DEBOUNCE_CYCLES (FIFO previously empty).
- FIFO:
  - Show-ahead: press_mask always equals the head entry; it is 0 when empty.
  - Pop on press_ack & press_valid.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push when full without pop: new entry dropped, overflow set. Overflow clears only on reset.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- flush:
  - Empties the FIFO that edge and takes priority over a simultaneous push/pop; the pushed entry is lost.
  - Debounce state and overflow are unaffected.
- Button held through reset release: it is debounced normally and produces one event DEBOUNCE_CYCLES later.
- Reset asserted mid-count or mid-handshake: everything returns to reset values on that edge; a pending ack is lost.
- State machine per lane: IDLE_UP, COUNT_DOWN, HELD, COUNT_UP. The counter value and key_level encode this; no separate state register is required.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, DEPTH=4):
1. Clean press: key_n[2] driven low at edge 0 and held → key_level=4'b0100 after edge 5, press_valid=1 with press_mask=4'b0100 after edge 6. press_ack for 1 cycle → press_valid=0. Releasing the key generates no new event.
2. Bounce: key_n[0] toggles low/high every 2 cycles for 20 cycles, then stays high → key_level stays 0, no event, counter never reaches 4.
3. Simultaneous: key_n[3] and key_n[1] fall on the same edge → exactly one entry, press_mask=4'b1010.
4. Overflow: 5 separate presses on lane 0 with no ack → 4 entries queued, 5th dropped, overflow=1. Four acks → press_valid drops after the 4th; overflow stays 1 until reset.
5. Full push+pop: with FIFO full, a press completes on the same edge press_ack=1 → count stays 4, overflow=0, new mask at tail. enable=0 press → nothing queued.
6. Reset/flush: reset pulsed while lane 1 counter=2 → key_level=0, FIFO empty. Key still low → event after 4 more stable cycles. flush with 3 entries → press_valid=0 on the next cycle.
